kgp_final_sum: RTL and testbench

KGP_FINAL_SUM -- requirements
Module: kgp_final_sum

---
 rtl/kgp_final_sum_if.sv | 17 +
 rtl/kgp_final_sum.sv | 58 +++++
 tb/tb_kgp_final_sum.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/kgp_final_sum_if.sv
// kgp_final_sum_if: input and output valid/ready channels of the KGP final-sum stage.
interface kgp_final_sum_if;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [127:0] in_carry;
   logic         out_valid;
   logic         out_ready;
   logic [63:0]  out_sum;
   logic         out_cout;
   logic         out_err;
   modport master (output in_valid, in_a, in_b, in_carry, out_ready,
                   input in_ready, out_valid, out_sum, out_cout, out_err);
   modport slave (input in_valid, in_a, in_b, in_carry, out_ready,
                  output in_ready, out_valid, out_sum, out_cout, out_err);
endinterface

// File: rtl/kgp_final_sum.sv
// kgp_final_sum: registered sum from a resolved KGP carry vector, with a 2-entry output FIFO.
module kgp_final_sum (
   input  logic             clk,
   input  logic             rst_n,
   kgp_final_sum_if.slave   bus,
   output logic             err_sticky,
   output logic [15:0]      result_cnt
);
   logic         s1_valid;
   logic [63:0]  s1_a, s1_b, hi, lo, sum;
   logic [127:0] s1_c;
   logic [65:0]  mem [2];
   logic         rd_ptr, wr_ptr, err, push, pop, accept;
   logic [1:0]   count;
   for (genvar g = 0; g < 64; g++) begin : g_split
      assign hi[g] = s1_c[2*g+1];
      assign lo[g] = s1_c[2*g];
   end
   // Upper bit of each position is the carry out; it still drives the sum when unresolved.
   assign sum = s1_a ^ s1_b ^ {hi[62:0], 1'b0};
   assign err = |(hi ^ lo);
   assign pop = bus.out_valid && bus.out_ready;
   assign push = s1_valid && (count != 2'd2 || pop);
   assign accept = bus.in_valid && bus.in_ready;
   assign bus.in_ready = !s1_valid || push;
   assign bus.out_valid = count != 2'd0;
   assign {bus.out_err, bus.out_cout, bus.out_sum} = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a <= '0;
         s1_b <= '0;
         s1_c <= '0;
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count <= '0;
         err_sticky <= 1'b0;
         result_cnt <= '0;
      end else begin
         if (accept) begin
            s1_a <= bus.in_a;
            s1_b <= bus.in_b;
            s1_c <= bus.in_carry;
         end
         s1_valid <= accept || (s1_valid && !push);
         if (push) begin
            mem[wr_ptr] <= {err, hi[63], sum};
            wr_ptr <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         count <= count + 2'(push) - 2'(pop);
         err_sticky <= err_sticky | (push & err);
         result_cnt <= result_cnt + 16'(pop);
      end
   end
endmodule

// File: tb/tb_kgp_final_sum.sv
// tb_kgp_final_sum: directed and random checks of kgp_final_sum against an adder-level model.
module tb_kgp_final_sum;
   typedef struct {logic [63:0] s; logic co; logic er;} res_t;
   logic clk = 1'b0;
   logic rst_n;
   logic err_sticky;
   logic [15:0] result_cnt;
   kgp_final_sum_if bus ();
   kgp_final_sum dut (.clk(clk), .rst_n(rst_n), .bus(bus), .err_sticky(err_sticky), .result_cnt(result_cnt));
   always #5 clk = ~clk;
   int n_assert = 0, n_fail = 0;
   res_t exp_q[$];
   res_t cur, e;
   logic [15:0] m_cnt;
   logic m_sticky, m_err_acc, acc;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // True KGP vector from real carries; position p (if any) is made propagate with its upper bit kept.
   function automatic logic [127:0] gen_carry(input logic [63:0] a, input logic [63:0] b, input int p);
      logic [127:0] c;
      logic [63:0] m;
      logic [64:0] t;
      for (int i = 0; i < 64; i++) begin
         m = (i == 63) ? '1 : (64'd1 << (i + 1)) - 64'd1;
         t = {1'b0, a & m} + {1'b0, b & m};
         c[2*i +: 2] = (i == p) ? {t[i+1], ~t[i+1]} : {t[i+1], t[i+1]};
      end
      return c;
   endfunction
   task automatic drive(input logic [63:0] a, input logic [63:0] b, input int p);
      bus.in_a = a;
      bus.in_b = b;
      bus.in_carry = gen_carry(a, b, p);
      {cur.co, cur.s} = {1'b0, a} + {1'b0, b};
      cur.er = (p >= 0);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cyc();
      #2;
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
         chk("pop_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum", bus.out_sum, e.s);
            chk("cout", bus.out_cout, e.co);
            chk("err", bus.out_err, e.er);
            if (e.er) m_sticky = 1'b1;
         end
         m_cnt++;
      end
      if (acc) begin
         exp_q.push_back(cur);
         if (cur.er) m_err_acc = 1'b1;
      end
      tick();
      chk("result_cnt", result_cnt, m_cnt);
      if (m_sticky) chk("sticky_set", err_sticky, 1'b1);
      else if (!m_err_acc) chk("sticky_clear", err_sticky, 1'b0);
   endtask
   task automatic model_reset();
      exp_q.delete();
      m_cnt = '0;
      m_sticky = 1'b0;
      m_err_acc = 1'b0;
   endtask
   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
      chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
      chk({tag, "_out_sum"}, bus.out_sum, 64'd0);
      chk({tag, "_out_cout"}, bus.out_cout, 1'b0);
      chk({tag, "_out_err"}, bus.out_err, 1'b0);
      chk({tag, "_sticky"}, err_sticky, 1'b0);
      chk({tag, "_cnt"}, result_cnt, 16'd0);
   endtask
   initial begin
      int k, pops;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      drive(64'd0, 64'd0, -1);
      model_reset();
      #2;
      chk_reset_state("reset");
      tick();
      tick();
      rst_n = 1'b1;
      // basic add and two-cycle latency
      drive(64'h1, 64'h1, -1);
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      chk("basic_carry_vec", bus.in_carry, 128'h3);
      chk("basic_in_ready", bus.in_ready, 1'b1);
      cyc();
      bus.in_valid = 1'b0;
      chk("basic_lat_n1", bus.out_valid, 1'b0);
      cyc();
      chk("basic_lat_n2", bus.out_valid, 1'b1);
      chk("basic_sum", bus.out_sum, 64'h2);
      chk("basic_cout", bus.out_cout, 1'b0);
      chk("basic_err", bus.out_err, 1'b0);
      cyc();
      chk("basic_cnt", result_cnt, 16'd1);
      // overflow
      drive('1, 64'h1, -1);
      bus.in_valid = 1'b1;
      chk("ovf_carry_vec", bus.in_carry, {128{1'b1}});
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      chk("ovf_sum", bus.out_sum, 64'd0);
      chk("ovf_cout", bus.out_cout, 1'b1);
      cyc();
      chk("ovf_cnt", result_cnt, 16'd2);
      // backpressure: four offered, three held
      bus.out_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         drive(64'(100 + k), 64'(k * 7), -1);
         bus.in_valid = 1'b1;
         cyc();
         if (acc) k++;
      end
      chk("bp_accepted", k, 3);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_stable_sum", bus.out_sum, 64'd100);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && k < 4; i++) begin
         drive(64'(100 + k), 64'(k * 7), -1);
         cyc();
         if (acc) k++;
      end
      chk("bp_fourth_accepted", k, 4);
      bus.in_valid = 1'b0;
      repeat (4) cyc();
      chk("bp_drained", exp_q.size(), 0);
      // error flag and sticky
      drive(64'd3, 64'd4, 5);
      chk("err_pos5", bus.in_carry[11:10], 2'b01);
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      chk("err_out", bus.out_err, 1'b1);
      chk("err_sum", bus.out_sum, 64'd7);
      cyc();
      chk("err_sticky_now", err_sticky, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(64'(i * 11), 64'(i + 1), -1);
         bus.in_valid = 1'b1;
         cyc();
      end
      bus.in_valid = 1'b0;
      repeat (3) cyc();
      chk("err_sticky_kept", err_sticky, 1'b1);
      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive({$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(7) == 0) ? int'($urandom_range(63)) : -1);
         bus.in_valid = $urandom_range(3) != 0;
         bus.out_ready = $urandom_range(3) != 0;
         cyc();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) cyc();
      chk("rand_drained", exp_q.size(), 0);
      // reset mid-stream with two queued results
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(64'(500 + i), 64'd1, -1);
         bus.in_valid = 1'b1;
         cyc();
      end
      bus.in_valid = 1'b0;
      repeat (2) cyc();
      chk("pre_reset_valid", bus.out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_reset_state("midrst");
      tick();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         cyc();
         chk("no_stale", bus.out_valid, 1'b0);
      end
      // counter wrap at full throughput
      drive(64'd5, 64'd6, -1);
      bus.in_valid = 1'b1;
      pops = 0;
      for (int i = 0; i < 70000 && pops < 65536; i++) begin
         #2;
         if (bus.out_valid && bus.out_ready) pops++;
         tick();
         if (pops == 65535) chk("cnt_ffff", result_cnt, 16'hFFFF);
      end
      chk("wrap_pops", pops, 65536);
      chk("wrap_cnt", result_cnt, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
